// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures high time and period of each servo PWM frame,
// decodes the pulse width into position 1..3 and flags bad frames / lost link.
//
// Ports:
//   clk, rst_n        : 50 MHz clock, asynchronous active-low reset
//   pwm_in            : asynchronous PWM input
//   width, period     : high time / rise-to-rise period of last frame (cycles)
//   position          : 1..3 for a valid frame, 0 for invalid / none
//   valid, bad_frame  : one-cycle strobes, one of them per published frame
//   signal_lost       : level, no rising edge for TIMEOUT cycles
module servo_pwm_decoder #(
    parameter int unsigned POS1_TICKS = 50_000,
    parameter int unsigned POS2_TICKS = 75_000,
    parameter int unsigned POS3_TICKS = 100_000,
    parameter int unsigned TOL_TICKS  = 5_000,
    parameter int unsigned PERIOD_MIN = 900_000,
    parameter int unsigned PERIOD_MAX = 1_100_000,
    parameter int unsigned TIMEOUT    = 2_000_000,
    parameter int unsigned CW         = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    output logic [CW-1:0] width,
    output logic [CW-1:0] period,
    output logic [1:0]    position,
    output logic          valid,
    output logic          bad_frame,
    output logic          signal_lost
);

    localparam logic [CW:0]   P1   = (CW+1)'(POS1_TICKS);
    localparam logic [CW:0]   P2   = (CW+1)'(POS2_TICKS);
    localparam logic [CW:0]   P3   = (CW+1)'(POS3_TICKS);
    localparam logic [CW:0]   TOL  = (CW+1)'(TOL_TICKS);
    localparam logic [CW-1:0] PMIN = CW'(PERIOD_MIN);
    localparam logic [CW-1:0] PMAX = CW'(PERIOD_MAX);
    localparam logic [CW-1:0] TMO  = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          s1_q, s2_q, s3_q;
    logic [1:0]    prime_q, prime_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] hi_cnt_q, hi_cnt_d;
    logic [CW-1:0] per_cnt_q, per_cnt_d;
    logic [CW-1:0] hi_lat_q, hi_lat_d;
    logic [CW-1:0] width_q, width_d;
    logic [CW-1:0] period_q, period_d;
    logic [1:0]    pos_q, pos_d;
    logic          valid_q, valid_d;
    logic          bad_q, bad_d;
    logic          lost_q, lost_d;

    logic          rise, fall;
    logic          per_sat;
    logic [CW-1:0] per_inc;
    logic [CW:0]   hi_ext, d1, d2, d3;
    logic          in1, in2, in3, per_ok;
    logic [1:0]    hit;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    assign per_sat = (per_cnt_q == TMO);
    assign per_inc = per_sat ? per_cnt_q : per_cnt_q + ONE;

    // Widen by one bit so |hi_lat - nominal| can never wrap.
    assign hi_ext = {1'b0, hi_lat_q};
    assign d1 = (hi_ext >= P1) ? hi_ext - P1 : P1 - hi_ext;
    assign d2 = (hi_ext >= P2) ? hi_ext - P2 : P2 - hi_ext;
    assign d3 = (hi_ext >= P3) ? hi_ext - P3 : P3 - hi_ext;
    assign in1 = (d1 <= TOL);
    assign in2 = (d2 <= TOL);
    assign in3 = (d3 <= TOL);
    assign hit = in1 ? 2'd1 : in2 ? 2'd2 : in3 ? 2'd3 : 2'd0;
    assign per_ok = (per_cnt_q >= PMIN) && (per_cnt_q <= PMAX);

    // A rise is only trusted once the synchronizer has shown a real low
    // after reset; an input already high at release is a partial frame.
    assign prime_d = {prime_q[0], 1'b1};
    assign armed_d = armed_q | (prime_q[1] & ~s2_q);

    always_comb begin
        state_d   = state_q;
        hi_cnt_d  = hi_cnt_q;
        per_cnt_d = per_cnt_q;
        hi_lat_d  = hi_lat_q;
        width_d   = width_q;
        period_d  = period_q;
        pos_d     = pos_q;
        valid_d   = 1'b0;
        bad_d     = 1'b0;
        lost_d    = lost_q;
        unique case (state_q)
            WAIT_RISE: begin
                if (rise && armed_q) begin
                    hi_cnt_d  = ONE;
                    per_cnt_d = ONE;
                    state_d   = MEAS_HIGH;
                end
            end
            MEAS_HIGH: begin
                if (per_sat) begin
                    state_d = WAIT_RISE;
                    lost_d  = 1'b1;
                    pos_d   = 2'd0;
                end else begin
                    per_cnt_d = per_inc;
                    if (fall) begin
                        hi_lat_d = hi_cnt_q;
                        state_d  = MEAS_LOW;
                    end else begin
                        hi_cnt_d = hi_cnt_q + ONE;
                    end
                end
            end
            MEAS_LOW: begin
                // Rise beats timeout: the frame publishes with the
                // saturated period and so decodes as bad.
                if (rise) begin
                    width_d  = hi_lat_q;
                    period_d = per_cnt_q;
                    lost_d   = 1'b0;
                    if (per_ok && (hit != 2'd0)) begin
                        pos_d   = hit;
                        valid_d = 1'b1;
                    end else begin
                        pos_d = 2'd0;
                        bad_d = 1'b1;
                    end
                    hi_cnt_d  = ONE;
                    per_cnt_d = ONE;
                    state_d   = MEAS_HIGH;
                end else if (per_sat) begin
                    state_d = WAIT_RISE;
                    lost_d  = 1'b1;
                    pos_d   = 2'd0;
                end else begin
                    per_cnt_d = per_inc;
                end
            end
            default: begin
                state_d = WAIT_RISE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            prime_q   <= 2'b00;
            armed_q   <= 1'b0;
            state_q   <= WAIT_RISE;
            hi_cnt_q  <= '0;
            per_cnt_q <= '0;
            hi_lat_q  <= '0;
            width_q   <= '0;
            period_q  <= '0;
            pos_q     <= 2'd0;
            valid_q   <= 1'b0;
            bad_q     <= 1'b0;
            lost_q    <= 1'b1;
        end else begin
            s1_q      <= pwm_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            prime_q   <= prime_d;
            armed_q   <= armed_d;
            state_q   <= state_d;
            hi_cnt_q  <= hi_cnt_d;
            per_cnt_q <= per_cnt_d;
            hi_lat_q  <= hi_lat_d;
            width_q   <= width_d;
            period_q  <= period_d;
            pos_q     <= pos_d;
            valid_q   <= valid_d;
            bad_q     <= bad_d;
            lost_q    <= lost_d;
        end
    end

    assign width       = width_q;
    assign period      = period_q;
    assign position    = pos_q;
    assign valid       = valid_q;
    assign bad_frame   = bad_q;
    assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb_servo_pwm_decoder: directed + random frames on a time-scaled decoder,
// checked against an arithmetic frame model.
module tb_servo_pwm_decoder;

    localparam int P1   = 50;
    localparam int P2   = 75;
    localparam int P3   = 100;
    localparam int TOL  = 5;
    localparam int PMIN = 900;
    localparam int PMAX = 1100;
    localparam int TMO  = 2000;
    localparam int CW   = 12;

    logic          clk;
    logic          rst_n;
    logic          pwm;
    logic [CW-1:0] width;
    logic [CW-1:0] period;
    logic [1:0]    position;
    logic          valid;
    logic          bad_frame;
    logic          signal_lost;

    servo_pwm_decoder #(
        .POS1_TICKS(P1),
        .POS2_TICKS(P2),
        .POS3_TICKS(P3),
        .TOL_TICKS (TOL),
        .PERIOD_MIN(PMIN),
        .PERIOD_MAX(PMAX),
        .TIMEOUT   (TMO),
        .CW        (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm),
        .width      (width),
        .period     (period),
        .position   (position),
        .valid      (valid),
        .bad_frame  (bad_frame),
        .signal_lost(signal_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit have_prev = 1'b0;
    int prev_h = 0;
    int prev_t = 0;
    int exp_lost = 1;
    int exp_valid = 0;
    int exp_bad = 0;
    int nvalid = 0;
    int nbad = 0;
    int nboth = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) nvalid++;
            if (bad_frame) nbad++;
            if (valid && bad_frame) nboth++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_pos(input int h, input int t);
        int nom[3];
        int d;
        nom[0] = P1;
        nom[1] = P2;
        nom[2] = P3;
        if (t < PMIN || t > PMAX) return 0;
        for (int k = 0; k < 3; k++) begin
            d = (h > nom[k]) ? h - nom[k] : nom[k] - h;
            if (d <= TOL) return k + 1;
        end
        return 0;
    endfunction

    task automatic no_strobe(input string tag);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_bad"}, int'(bad_frame), 0);
    endtask

    task automatic check_pub(input int h, input int t);
        int p;
        p = ref_pos(h, t);
        chk("width", int'(width), h);
        chk("period", int'(period), t);
        chk("position", int'(position), p);
        chk("valid", int'(valid), (p != 0) ? 1 : 0);
        chk("bad_frame", int'(bad_frame), (p == 0) ? 1 : 0);
        chk("lost_clr", int'(signal_lost), 0);
        if (p != 0) exp_valid++;
        else exp_bad++;
        exp_lost = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_width"}, int'(width), 0);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_pos"}, int'(position), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_bad"}, int'(bad_frame), 0);
        chk({tag, "_lost"}, int'(signal_lost), 1);
    endtask

    // Frame starts with a rise; the rise closes the previous frame,
    // whose publish lands 3 edges after pwm is driven high.
    task automatic run_frame(input int h, input int t);
        pwm = 1'b1;
        for (int i = 1; i <= t; i++) begin
            @(posedge clk);
            #1;
            if (i == h) pwm = 1'b0;
            if (i == 2) no_strobe("early");
            if (i == 3) begin
                if (have_prev) begin
                    check_pub(prev_h, prev_t);
                end else begin
                    no_strobe("nopub");
                    chk("lost_idle", int'(signal_lost), exp_lost);
                end
            end
            if (i == 4) no_strobe("late");
        end
        prev_h = h;
        prev_t = t;
        have_prev = 1'b1;
    endtask

    initial begin
        int h;
        int t;
        int k;
        rst_n = 1'b0;
        pwm   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_reset_vals("idle");

        run_frame(50, 1000);
        run_frame(50, 1000);
        run_frame(50, 1000);
        run_frame(75, 1000);
        run_frame(100, 1000);
        run_frame(55, 1000);
        run_frame(56, 1000);
        run_frame(50, 1101);
        run_frame(45, 900);
        run_frame(105, 1100);
        run_frame(44, 1000);

        for (int r = 0; r < 6; r++) begin
            k = int'($urandom_range(0, 3));
            if (k == 0) h = int'($urandom_range(20, 130));
            else h = 25 * k + 25 + int'($urandom_range(0, 14)) - 7;
            t = int'($urandom_range(880, 1120));
            run_frame(h, t);
        end

        // Stuck high: closing rise publishes, then the link times out.
        pwm = 1'b1;
        for (int i = 1; i <= TMO + 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) check_pub(prev_h, prev_t);
            if (i == 4) no_strobe("stuck");
            if (i == TMO + 2) chk("lost_pre", int'(signal_lost), 0);
            if (i == TMO + 3) begin
                chk("lost_set", int'(signal_lost), 1);
                chk("lost_pos", int'(position), 0);
                chk("lost_width", int'(width), prev_h);
                chk("lost_period", int'(period), prev_t);
            end
        end
        have_prev = 1'b0;
        exp_lost  = 1;
        pwm = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        run_frame(75, 1000);
        run_frame(100, 1000);
        run_frame(50, 1000);

        // Reset 30 cycles into a high pulse.
        pwm = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) check_pub(prev_h, prev_t);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        have_prev = 1'b0;
        exp_lost  = 1;
        for (int i = 31; i <= 1000; i++) begin
            @(posedge clk);
            #1;
            if (i == 33) rst_n = 1'b1;
            if (i == 50) pwm = 1'b0;
            if (i == 60) check_reset_vals("partial");
        end
        run_frame(50, 1000);
        run_frame(75, 1000);

        // 1-cycle high / 1-cycle low stream.
        for (int j = 0; j < 8; j++) begin
            pwm = 1'b1;
            @(posedge clk);
            #1;
            if (j == 1) check_pub(prev_h, prev_t);
            else if (j >= 2) check_pub(1, 2);
            pwm = 1'b0;
            @(posedge clk);
            #1;
            no_strobe("short");
        end
        @(posedge clk);
        #1;
        check_pub(1, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("n_valid", nvalid, exp_valid);
        chk("n_bad", nbad, exp_bad);
        chk("n_both", nboth, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/servo_pwm_decoder.md
# servo_pwm_decoder

Receive side of the servo PWM link: it samples a 50 Hz servo control waveform on `pwm_in` and measures the high time and period of each frame in 50 MHz clock cycles. It decodes the pulse width into one of the three servo positions (1 ms, 1.5 ms, 2 ms) and flags frames and links that are out of spec. It is used as a loop-back checker for the servo driver and as a front end for boards that receive servo commands from an external controller.

## Interface

Parameters:
- `POS1_TICKS`, default 50_000: nominal high time for position 1 (1 ms).
- `POS2_TICKS`, default 75_000: nominal high time for position 2 (1.5 ms).
- `POS3_TICKS`, default 100_000: nominal high time for position 3 (2 ms).
- `TOL_TICKS`, default 5_000: allowed deviation, inclusive, on either side of each nominal high time.
- `PERIOD_MIN`, default 900_000: minimum accepted period, inclusive.
- `PERIOD_MAX`, default 1_100_000: maximum accepted period, inclusive.
- `TIMEOUT`, default 2_000_000: number of cycles without a rising edge before the link is declared lost.
- `CW`, default 21: counter width. It must satisfy 2^CW > TIMEOUT.

Ports (clock and reset first):
- `clk`, input, 1 bit: single clock, 50 MHz.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `pwm_in`, input, 1 bit: asynchronous PWM input.
- `width`, output, CW bits: high time of the last completed frame, in cycles.
- `period`, output, CW bits: rising-to-rising period of the last completed frame, in cycles.
- `position`, output, 2 bits: decoded position. 1, 2 or 3 for a valid frame; 0 for an invalid frame or no frame.
- `valid`, output, 1 bit: one-cycle strobe; the frame was published and is in spec.
- `bad_frame`, output, 1 bit: one-cycle strobe; the frame was published and is out of spec.
- `signal_lost`, output, 1 bit: level; no rising edge has been seen for TIMEOUT cycles.

## Operation

- **Input conditioning:** `pwm_in` passes through a 2-flop synchronizer (`s1`, `s2`) plus a history flop `s3`.
  - `rise` = `s2 & ~s3`.
  - `fall` = `~s2 & s3`.
- **Counters:**
  - `hi_cnt` counts cycles with `s2` high.
  - `per_cnt` counts cycles since the last rise.
  - `per_cnt` saturates at TIMEOUT.
- **States:**
  - `WAIT_RISE`: entered from reset and on timeout. The first partial frame is discarded. On `rise`: `hi_cnt`←1, `per_cnt`←1, go to `MEAS_HIGH`.
  - `MEAS_HIGH`: both counters increment each cycle. On `fall`: latch `hi_cnt` into `hi_lat`, go to `MEAS_LOW`.
  - `MEAS_LOW`: `per_cnt` increments each cycle. On `rise`: publish the frame (`width`←`hi_lat`, `period`←`per_cnt`, decode), then `hi_cnt`←1, `per_cnt`←1, go to `MEAS_HIGH`.
- **Decode at publish:**
  - `period` must lie in [PERIOD_MIN, PERIOD_MAX].
  - `position` = k for the first k (1..3) with |`hi_lat` − POSk_TICKS| ≤ TOL_TICKS.
  - If both hold, assert `valid`. Otherwise set `position`←0 and assert `bad_frame`.
  - Exactly one of `valid` / `bad_frame` pulses per publish.
- **Width arithmetic:** the absolute difference is computed in CW+1 bits, so no wrap-around can occur.
- **Timeout:** in `MEAS_HIGH` or `MEAS_LOW`, when `per_cnt` reaches TIMEOUT:
  - go to `WAIT_RISE`;
  - set `signal_lost`←1 and `position`←0;
  - no strobe is issued;
  - `width` and `period` hold their values.
  - This covers an input stuck high and an input stuck low.
- **`signal_lost` clearing:** cleared on the next publish, whether valid or bad.
- **Rise and timeout in the same cycle:** the rise wins. The frame is published with `period` = TIMEOUT, which is out of range, so `bad_frame` pulses.
- **Reset values:**
  - `width`=0, `period`=0, `position`=0, `valid`=0, `bad_frame`=0.
  - `signal_lost`=1.
  - Synchronizer flops = 0; state = `WAIT_RISE`.
- **Reset mid-frame:** asserting `rst_n` low at any time returns all outputs to reset values immediately (asynchronous). After release the block waits for a fresh rise.

## Timing

- **Input-to-`s2` latency:** `pwm_in` sampled high at clock edge n appears on `s2` at edge n+1.
- **Publish latency:** `rise` is decoded in the cycle after edge n+1; `width`, `period`, `position`, `valid` and `bad_frame` update at edge n+2.
  - So outputs lag the input edge that closes the frame by 2 cycles.
- **Exact counting:** a pulse held high for exactly P cycles gives `width` = P; a frame of exactly T cycles gives `period` = T.
- **Strobes:** `valid` and `bad_frame` are high for exactly one cycle. They are never asserted together.
- **Minimum pulse:** pulses or gaps shorter than one clock may be missed. A 1-cycle high or a 1-cycle low is measured correctly.
- **Timeout latency:** `signal_lost` rises TIMEOUT cycles after the last internal `rise` (edge n+2 relative to the input edge, plus TIMEOUT).

## Test plan

- **Position 1:** after reset, drive 3 frames of 50_000 cycles high / 1_000_000 period → the 1st partial frame is ignored; then `valid` pulses with `width`=50_000, `period`=1_000_000, `position`=1; `signal_lost` falls at the first publish.
- **Positions 2 and 3:** frames of 75_000 and 100_000 cycles high, 1_000_000 period → `position`=2, then `position`=3; `valid` pulses once per frame, 2 cycles after each closing rise.
- **Tolerance boundaries:**
  - 55_000 high → `position`=1, `valid`.
  - 55_001 high → `position`=0, `bad_frame`.
  - Period 1_100_001 → `bad_frame`.
- **Stuck input:** hold `pwm_in`=1 after a valid frame → no strobe; `signal_lost`=1 and `position`=0 exactly 2_000_000 cycles after the last rise; the next two good frames restore `valid`.
- **Reset mid-frame:** assert `rst_n`=0 30_000 cycles into a high pulse → all outputs return to reset values asynchronously; after release the partial frame is ignored and the next full frame decodes correctly.
- **Short pulses:** 1-cycle high, 1-cycle low stream (period 2) → `bad_frame` every frame with `width`=1, `period`=2; `valid` is never asserted.
